// File: rtl/timer_bank_if.sv
// Peripheral bus bundle for timer_bank: word-addressed load/store plus the interrupt line.
interface timer_bank_if;
    logic [31:0] addr;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    modport master (
        output addr, wr_en, rd_en, wdata,
        input  rdata, irq
    );

    modport slave (
        input  addr, wr_en, rd_en, wdata,
        output rdata, irq
    );
endinterface

// File: rtl/timer_bank.sv
// Bank of N reload timers (TH/TL/TCON/PRESC per channel) with a shared W1C status word.
// Reads are combinational; writes, prescaling and counting happen on the clock edge.
module timer_bank #(
    parameter int unsigned N_TIMERS  = 2,
    parameter int unsigned TIMER_W   = 32,
    parameter int unsigned PRESC_W   = 8,
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
    input logic         clk_i,
    input logic         rst_i,
    timer_bank_if.slave bus_io
);

    logic [31:0]         off;
    logic [N_TIMERS-1:0] ch_hit;
    logic                stat_hit;
    logic                unused_off;

    // Addresses below BASE_ADDR wrap to a huge offset and decode as unmapped.
    assign off        = bus_io.addr - BASE_ADDR;
    assign stat_hit   = (off[31:2] == 30'(4 * N_TIMERS));
    assign unused_off = ^off[1:0];

    always_comb begin
        for (int k = 0; k < N_TIMERS; k++) begin
            ch_hit[k] = (off[31:4] == 28'(k));
        end
    end

    logic [TIMER_W-1:0]  th_q    [N_TIMERS];
    logic [TIMER_W-1:0]  th_d    [N_TIMERS];
    logic [TIMER_W-1:0]  tl_q    [N_TIMERS];
    logic [TIMER_W-1:0]  tl_d    [N_TIMERS];
    logic [PRESC_W-1:0]  presc_q [N_TIMERS];
    logic [PRESC_W-1:0]  presc_d [N_TIMERS];
    logic [PRESC_W-1:0]  pc_q    [N_TIMERS];
    logic [PRESC_W-1:0]  pc_d    [N_TIMERS];
    logic [N_TIMERS-1:0] en_q, en_d;
    logic [N_TIMERS-1:0] ie_q, ie_d;
    logic [N_TIMERS-1:0] flag_q, flag_d;
    logic [N_TIMERS-1:0] os_q, os_d;

    logic [N_TIMERS-1:0] wr_th, wr_tl, wr_tcon, wr_presc;
    logic                wr_stat;
    logic [N_TIMERS-1:0] tick, ovf;

    always_comb begin
        wr_th    = '0;
        wr_tl    = '0;
        wr_tcon  = '0;
        wr_presc = '0;
        for (int k = 0; k < N_TIMERS; k++) begin
            if (bus_io.wr_en && ch_hit[k]) begin
                unique case (off[3:2])
                    2'd0: wr_th[k]    = 1'b1;
                    2'd1: wr_tl[k]    = 1'b1;
                    2'd2: wr_tcon[k]  = 1'b1;
                    2'd3: wr_presc[k] = 1'b1;
                endcase
            end
        end
    end

    assign wr_stat = bus_io.wr_en && stat_hit;

    // A CPU write to TL swallows a coincident tick, so it cannot overflow either.
    always_comb begin
        for (int k = 0; k < N_TIMERS; k++) begin
            tick[k] = en_q[k] && (pc_q[k] == presc_q[k]);
            ovf[k]  = tick[k] && (&tl_q[k]) && !wr_tl[k];
        end
    end

    always_comb begin
        en_d   = en_q;
        ie_d   = ie_q;
        os_d   = os_q;
        flag_d = flag_q;
        for (int k = 0; k < N_TIMERS; k++) begin
            th_d[k]    = wr_th[k] ? bus_io.wdata[TIMER_W-1:0] : th_q[k];
            presc_d[k] = wr_presc[k] ? bus_io.wdata[PRESC_W-1:0] : presc_q[k];

            if (!en_q[k] || wr_presc[k] || tick[k]) begin
                pc_d[k] = '0;
            end else begin
                pc_d[k] = pc_q[k] + 1'b1;
            end

            if (wr_tl[k]) begin
                tl_d[k] = bus_io.wdata[TIMER_W-1:0];
            end else if (ovf[k]) begin
                tl_d[k] = th_q[k];
            end else if (tick[k]) begin
                tl_d[k] = tl_q[k] + 1'b1;
            end else begin
                tl_d[k] = tl_q[k];
            end

            if (wr_tcon[k]) begin
                en_d[k] = bus_io.wdata[0];
                ie_d[k] = bus_io.wdata[1];
                os_d[k] = bus_io.wdata[3];
                if (bus_io.wdata[2]) begin
                    flag_d[k] = 1'b0;
                end
            end else if (ovf[k] && os_q[k]) begin
                en_d[k] = 1'b0;
            end

            if (wr_stat && bus_io.wdata[k]) begin
                flag_d[k] = 1'b0;
            end
            // Overflow set is applied last so it beats any same-cycle clear.
            if (ovf[k] && ie_q[k]) begin
                flag_d[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < N_TIMERS; k++) begin
                th_q[k]    <= '0;
                tl_q[k]    <= '1;
                presc_q[k] <= '0;
                pc_q[k]    <= '0;
            end
            en_q   <= '0;
            ie_q   <= '0;
            flag_q <= '0;
            os_q   <= '0;
        end else begin
            th_q    <= th_d;
            tl_q    <= tl_d;
            presc_q <= presc_d;
            pc_q    <= pc_d;
            en_q    <= en_d;
            ie_q    <= ie_d;
            flag_q  <= flag_d;
            os_q    <= os_d;
        end
    end

    logic [31:0] rd_data;

    always_comb begin
        rd_data = '0;
        if (bus_io.rd_en) begin
            if (stat_hit) begin
                rd_data[N_TIMERS-1:0] = flag_q;
            end
            for (int k = 0; k < N_TIMERS; k++) begin
                if (ch_hit[k]) begin
                    unique case (off[3:2])
                        2'd0: rd_data[TIMER_W-1:0] = th_q[k];
                        2'd1: rd_data[TIMER_W-1:0] = tl_q[k];
                        2'd2: rd_data[3:0]         = {os_q[k], flag_q[k], ie_q[k], en_q[k]};
                        2'd3: rd_data[PRESC_W-1:0] = presc_q[k];
                    endcase
                end
            end
        end
    end

    assign bus_io.rdata = rd_data;
    assign bus_io.irq   = |(flag_q & ie_q);

endmodule

// File: tb/tb_timer_bank.sv
// Self-checking bench for timer_bank: directed scenarios plus randomized traffic
// compared against a per-channel behavioural model.
module tb_timer_bank;
    localparam int unsigned N    = 2;
    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [31:0] STAT = BASE + 32'(16 * N);

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    timer_bank_if bus ();

    timer_bank #(
        .N_TIMERS (N),
        .TIMER_W  (32),
        .PRESC_W  (8),
        .BASE_ADDR(BASE)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus_io(bus)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    logic [31:0] m_th    [N];
    logic [31:0] m_tl    [N];
    logic [7:0]  m_presc [N];
    int          m_pc    [N];
    bit          m_en    [N];
    bit          m_ie    [N];
    bit          m_flag  [N];
    bit          m_os    [N];

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_th[k] = 0; m_tl[k] = 32'hFFFF_FFFF; m_presc[k] = 0; m_pc[k] = 0;
            m_en[k] = 0; m_ie[k] = 0; m_flag[k] = 0; m_os[k] = 0;
        end
    endtask

    task automatic model_edge(input bit wr, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] off;
        int ch, word;
        bit stat_wr, mine, tick, ovf, set_flag, stop;
        off     = a - BASE;
        ch      = (off < 32'(16 * N)) ? int'(off[31:4]) : -1;
        word    = int'(off[3:2]);
        stat_wr = wr && (off[31:2] == 30'(4 * N));
        for (int k = 0; k < N; k++) begin
            mine = wr && (ch == k);
            tick = m_en[k] && (m_pc[k] == int'(m_presc[k]));
            ovf  = 0;
            if (mine && word == 1) m_tl[k] = d;
            else if (tick) begin
                if (m_tl[k] == 32'hFFFF_FFFF) begin
                    ovf = 1;
                    m_tl[k] = m_th[k];
                end else m_tl[k] = m_tl[k] + 1;
            end
            set_flag = ovf && m_ie[k];
            stop     = ovf && m_os[k];
            if (!m_en[k] || tick || (mine && word == 3)) m_pc[k] = 0;
            else m_pc[k] = m_pc[k] + 1;
            if (mine && word == 0) m_th[k] = d;
            if (mine && word == 3) m_presc[k] = d[7:0];
            if (mine && word == 2) begin
                m_en[k] = d[0]; m_ie[k] = d[1]; m_os[k] = d[3];
                if (d[2]) m_flag[k] = 0;
            end else if (stop) m_en[k] = 0;
            if (stat_wr && d[k]) m_flag[k] = 0;
            if (set_flag) m_flag[k] = 1;
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        logic [31:0] off, r;
        int ch;
        off = a - BASE;
        r   = 0;
        if (off[31:2] == 30'(4 * N)) begin
            for (int k = 0; k < N; k++) r[k] = m_flag[k];
        end else if (off < 32'(16 * N)) begin
            ch = int'(off[31:4]);
            case (off[3:2])
                2'd0: r = m_th[ch];
                2'd1: r = m_tl[ch];
                2'd2: r = {28'b0, m_os[ch], m_flag[ch], m_ie[ch], m_en[ch]};
                default: r = {24'b0, m_presc[ch]};
            endcase
        end
        return r;
    endfunction

    function automatic logic model_irq();
        logic r = 0;
        for (int k = 0; k < N; k++) r |= m_flag[k] & m_ie[k];
        return r;
    endfunction

    // One clock edge; the model advances with the same bus values the DUT sampled.
    task automatic step(input bit wr, input logic [31:0] a, input logic [31:0] d);
        bus.wr_en = wr; bus.addr = a; bus.wdata = d; bus.rd_en = 0;
        @(posedge clk);
        if (rst) model_reset();
        else model_edge(wr, a, d);
        #1;
        bus.wr_en = 0;
    endtask

    task automatic rd(input logic [31:0] a);
        bus.addr = a; bus.rd_en = 1; #1;
    endtask

    task automatic test_reset();
        logic [31:0] exp_w [4];
        exp_w[0] = 0; exp_w[1] = 32'hFFFF_FFFF; exp_w[2] = 0; exp_w[3] = 0;
        rst = 1;
        step(0, 0, 0);
        step(0, 0, 0);
        rst = 0;
        for (int w = 0; w < 4; w++) begin
            rd(BASE + 32'(4 * w));
            vectors++;
            if (bus.rdata !== exp_w[w]) begin
                miscompares++;
                $display("FAIL reset_word%0d got=%h exp=%h", w, bus.rdata, exp_w[w]);
            end
        end
        rd(STAT);
        vectors++;
        if (bus.rdata !== 32'h0) begin
            miscompares++; $display("FAIL reset_status got=%h exp=0", bus.rdata);
        end
        vectors++;
        if (bus.irq !== 1'b0) begin
            miscompares++; $display("FAIL reset_irq got=%b exp=0", bus.irq);
        end
        bus.addr = BASE + 4; bus.rd_en = 0; #1;
        vectors++;
        if (bus.rdata !== 32'h0) begin
            miscompares++; $display("FAIL rd_en_low got=%h exp=0", bus.rdata);
        end
    endtask

    task automatic test_overflow_irq();
        logic [31:0] seq [4];
        seq[0] = 32'hFFFF_FFFD; seq[1] = 32'hFFFF_FFFE; seq[2] = 32'hFFFF_FFFF;
        seq[3] = 32'hFFFF_FFFD;
        step(1, BASE + 0, 32'hFFFF_FFFD);
        step(1, BASE + 4, 32'hFFFF_FFFD);
        step(1, BASE + 12, 0);
        step(1, BASE + 8, 3);
        for (int i = 0; i < 4; i++) begin
            rd(BASE + 4);
            vectors++;
            if (bus.rdata !== seq[i]) begin
                miscompares++; $display("FAIL ovf_tl%0d got=%h exp=%h", i, bus.rdata, seq[i]);
            end
            vectors++;
            if (bus.irq !== (i == 3)) begin
                miscompares++; $display("FAIL ovf_irq%0d got=%b exp=%b", i, bus.irq, i == 3);
            end
            if (i < 3) step(0, 0, 0);
        end
        rd(STAT);
        vectors++;
        if (bus.rdata !== 32'h1) begin
            miscompares++; $display("FAIL ovf_status got=%h exp=1", bus.rdata);
        end
        step(1, STAT, 1);
        vectors++;
        if (bus.irq !== 1'b0) begin
            miscompares++; $display("FAIL ovf_irq_clear got=%b exp=0", bus.irq);
        end
        step(1, BASE + 8, 0);
    endtask

    task automatic test_prescaler();
        logic [31:0] exp_tl;
        step(1, BASE + 16 + 12, 3);
        step(1, BASE + 16 + 4, 0);
        step(1, BASE + 16 + 8, 1);
        for (int i = 0; i < 9; i++) begin
            rd(BASE + 16 + 4);
            exp_tl = 32'(i / 4);
            vectors++;
            if (bus.rdata !== exp_tl) begin
                miscompares++; $display("FAIL presc_tl%0d got=%h exp=%h", i, bus.rdata, exp_tl);
            end
            step(0, 0, 0);
        end
        step(1, BASE + 16 + 4, 32'hFFFF_FFFF);
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (bus.irq !== 1'b0) begin
                miscompares++; $display("FAIL presc_irq%0d got=%b exp=0", i, bus.irq);
            end
            rd(BASE + 16 + 4);
            vectors++;
            if (bus.rdata !== model_rd(BASE + 20)) begin
                miscompares++;
                $display("FAIL presc_wrap%0d got=%h exp=%h", i, bus.rdata, model_rd(BASE + 20));
            end
            step(0, 0, 0);
        end
        rd(STAT);
        vectors++;
        if (bus.rdata !== 32'h0) begin
            miscompares++; $display("FAIL presc_noflag got=%h exp=0", bus.rdata);
        end
        step(1, BASE + 16 + 8, 0);
    endtask

    task automatic test_oneshot();
        step(1, BASE + 0, 32'h10);
        step(1, BASE + 4, 32'hFFFF_FFFF);
        step(1, BASE + 8, 32'hB);
        step(0, 0, 0);
        rd(BASE + 4);
        vectors++;
        if (bus.rdata !== 32'h10) begin
            miscompares++; $display("FAIL os_reload got=%h exp=10", bus.rdata);
        end
        rd(BASE + 8);
        vectors++;
        if (bus.rdata !== 32'hE) begin
            miscompares++; $display("FAIL os_tcon got=%h exp=e", bus.rdata);
        end
        step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
        rd(BASE + 4);
        vectors++;
        if (bus.rdata !== 32'h10) begin
            miscompares++; $display("FAIL os_hold got=%h exp=10", bus.rdata);
        end
        rd(STAT);
        vectors++;
        if (bus.rdata !== 32'h1) begin
            miscompares++; $display("FAIL os_flag got=%h exp=1", bus.rdata);
        end
        step(1, BASE + 8, 4);
        vectors++;
        if (bus.irq !== 1'b0) begin
            miscompares++; $display("FAIL os_irq_clear got=%b exp=0", bus.irq);
        end
    endtask

    task automatic test_collisions();
        step(1, BASE + 0, 0);
        step(1, BASE + 4, 32'hFFFF_FFFE);
        step(1, BASE + 8, 3);
        step(0, 0, 0);
        step(1, STAT, 1);
        rd(STAT);
        vectors++;
        if (bus.rdata !== 32'h1) begin
            miscompares++; $display("FAIL col_set_wins got=%h exp=1", bus.rdata);
        end
        rd(BASE + 4);
        vectors++;
        if (bus.rdata !== 32'h0) begin
            miscompares++; $display("FAIL col_reload got=%h exp=0", bus.rdata);
        end
        step(1, BASE + 4, 5);
        rd(BASE + 4);
        vectors++;
        if (bus.rdata !== 32'h5) begin
            miscompares++; $display("FAIL col_tl_write got=%h exp=5", bus.rdata);
        end
        step(0, 0, 0);
        rd(BASE + 4);
        vectors++;
        if (bus.rdata !== 32'h6) begin
            miscompares++; $display("FAIL col_tl_next got=%h exp=6", bus.rdata);
        end
        step(1, BASE + 4, 32'hFFFF_FFFF);
        step(1, BASE + 0, 32'h77);
        rd(BASE + 4);
        vectors++;
        if (bus.rdata !== 32'h0) begin
            miscompares++; $display("FAIL col_old_th got=%h exp=0", bus.rdata);
        end
        rd(BASE + 0);
        vectors++;
        if (bus.rdata !== 32'h77) begin
            miscompares++; $display("FAIL col_new_th got=%h exp=77", bus.rdata);
        end
        step(1, BASE + 8, 4);
        step(1, BASE + 8, 3);
        step(1, BASE + 4, 32'hFFFF_FFFF);
        step(1, BASE + 8, 2);
        rd(BASE + 4);
        vectors++;
        if (bus.rdata !== 32'h77) begin
            miscompares++; $display("FAIL col_en0_reload got=%h exp=77", bus.rdata);
        end
        rd(BASE + 8);
        vectors++;
        if (bus.rdata !== 32'h6) begin
            miscompares++; $display("FAIL col_en0_tcon got=%h exp=6", bus.rdata);
        end
        step(1, BASE + 8, 4);
    endtask

    task automatic test_unmapped();
        step(1, STAT + 4, 32'hFFFF_FFFF);
        step(1, BASE - 4, 32'hFFFF_FFFF);
        rd(STAT + 4);
        vectors++;
        if (bus.rdata !== 32'h0) begin
            miscompares++; $display("FAIL unmapped_rd got=%h exp=0", bus.rdata);
        end
        rd(BASE - 4);
        vectors++;
        if (bus.rdata !== 32'h0) begin
            miscompares++; $display("FAIL below_base_rd got=%h exp=0", bus.rdata);
        end
        for (int w = 0; w < 4 * N; w++) begin
            rd(BASE + 32'(4 * w));
            vectors++;
            if (bus.rdata !== model_rd(BASE + 32'(4 * w))) begin
                miscompares++;
                $display("FAIL unmapped_keep%0d got=%h exp=%h", w, bus.rdata,
                         model_rd(BASE + 32'(4 * w)));
            end
            if (w == 3) step(0, 0, 0);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, d, exp_r;
        int sel, word;
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 8) a = BASE + 32'(16 * (sel % N)) + 32'(4 * $urandom_range(0, 3));
            else if (sel == 8) a = STAT;
            else a = STAT + 32'(4 * $urandom_range(1, 3));
            a = a | 32'($urandom_range(0, 3));
            word = int'(a[3:2]);
            bus.addr = a; bus.rd_en = ($urandom_range(0, 9) != 0); #1;
            exp_r = bus.rd_en ? model_rd(a) : 32'h0;
            vectors++;
            if (bus.rdata !== exp_r) begin
                miscompares++; $display("FAIL rand_rd%0d a=%h got=%h exp=%h", i, a, bus.rdata, exp_r);
            end
            vectors++;
            if (bus.irq !== model_irq()) begin
                miscompares++; $display("FAIL rand_irq%0d got=%b exp=%b", i, bus.irq, model_irq());
            end
            if (sel == 8) d = 32'($urandom_range(0, 3));
            else if (word == 2) d = 32'($urandom_range(0, 15));
            else if (word == 3) d = 32'($urandom_range(0, 3));
            else if ($urandom_range(0, 1) == 1) d = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else d = $urandom;
            rst = ($urandom_range(0, 99) == 0);
            step($urandom_range(0, 2) == 0, a, d);
            rst = 0;
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] exp_w [4];
        exp_w[0] = 0; exp_w[1] = 32'hFFFF_FFFF; exp_w[2] = 0; exp_w[3] = 0;
        step(1, BASE + 16 + 12, 0);
        step(1, BASE + 16 + 0, 32'h1234);
        step(1, BASE + 16 + 8, 3);
        step(0, 0, 0); step(0, 0, 0);
        rst = 1;
        step(0, 0, 0);
        rst = 0;
        for (int c = 0; c < N; c++) begin
            for (int w = 0; w < 4; w++) begin
                rd(BASE + 32'(16 * c + 4 * w));
                vectors++;
                if (bus.rdata !== exp_w[w]) begin
                    miscompares++;
                    $display("FAIL midrst_ch%0d_w%0d got=%h exp=%h", c, w, bus.rdata, exp_w[w]);
                end
            end
            step(0, 0, 0);
        end
        rd(STAT);
        vectors++;
        if (bus.rdata !== 32'h0) begin
            miscompares++; $display("FAIL midrst_status got=%h exp=0", bus.rdata);
        end
        vectors++;
        if (bus.irq !== 1'b0) begin
            miscompares++; $display("FAIL midrst_irq got=%b exp=0", bus.irq);
        end
    endtask

    initial begin
        bus.addr = 0; bus.wr_en = 0; bus.rd_en = 0; bus.wdata = 0;
        model_reset();
        test_reset();
        test_overflow_irq();
        test_prescaler();
        test_oneshot();
        test_collisions();
        test_unmapped();
        test_random();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
